// File: rtl/prod_acc.sv
// Frame accumulator behind the multiplier: sums LEN products per frame, hands the sum off via valid/ready.
// Optional PROD_ACC_SAT_EN: clamp the accumulator to all-ones on overflow instead of wrapping.
module prod_acc #(
    parameter int unsigned PW  = 8,
    parameter int unsigned AW  = 16,
    parameter int unsigned LEN = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          in_vld_i,
    input  logic [PW-1:0] in_prod_i,
    output logic          in_rdy_o,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [AW-1:0] out_sum_o,
    output logic          out_ovf_o
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    localparam logic [7:0] LastCnt = 8'(LEN - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] sum_q, sum_d;
    logic          sum_ovf_q, sum_ovf_d;

    logic          accept;
    logic          frame_end;
    logic [AW-1:0] prod_ext;
    logic [AW:0]   add_full;
    logic          ovf_next;
    logic [AW-1:0] add_res;

    // Ready drops combinationally during reset so nothing is taken while rst_ni is low.
    assign in_rdy_o  = rst_ni & (state_q != StDone);
    assign accept    = in_vld_i & in_rdy_o;
    assign out_vld_o = (state_q == StDone);
    assign out_sum_o = sum_q;
    assign out_ovf_o = sum_ovf_q;

    assign prod_ext = AW'(in_prod_i);
    assign add_full = {1'b0, acc_q} + {1'b0, prod_ext};
    assign ovf_next = ovf_q | add_full[AW];

`ifdef PROD_ACC_SAT_EN
    // Once the frame has overflowed the accumulator stays pinned at all-ones.
    assign add_res = ovf_next ? {AW{1'b1}} : add_full[AW-1:0];
`else
    assign add_res = add_full[AW-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;
        frame_end = 1'b0;

        unique case (state_q)
            StIdle, StAcc: begin
                if (clr_i) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (accept) begin
                    if (state_q == StIdle) begin
                        acc_d     = prod_ext;
                        cnt_d     = 8'd1;
                        ovf_d     = 1'b0;
                        frame_end = (LEN == 1);
                    end else begin
                        acc_d     = add_res;
                        cnt_d     = cnt_q + 8'd1;
                        ovf_d     = ovf_next;
                        frame_end = (cnt_q == LastCnt);
                    end
                    if (frame_end) begin
                        state_d   = StDone;
                        sum_d     = acc_d;
                        sum_ovf_d = ovf_d;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StDone: begin
                // Frame abort is ignored here so a finished result is never dropped.
                if (out_rdy_i) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

endmodule

// File: tb/tb_prod_acc.sv
// Bench for prod_acc: three instances (LEN=4/AW=16, LEN=4/AW=9, LEN=1/AW=16), directed table plus
// randomized traffic checked against a frame-total reference model.
module tb_prod_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr  [3];
    logic       vld  [3];
    logic [7:0] prod [3];
    logic       ordy [3];
    logic       rdy  [3];
    logic       ovld [3];
    logic       oovf [3];
    logic [15:0] sum0, sum2;
    logic [8:0]  sum1;

    int checks = 0;
    int errors = 0;

    prod_acc #(.PW(8), .AW(16), .LEN(4)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .in_vld_i(vld[0]), .in_prod_i(prod[0]),
        .in_rdy_o(rdy[0]), .out_vld_o(ovld[0]), .out_rdy_i(ordy[0]), .out_sum_o(sum0),
        .out_ovf_o(oovf[0])
    );
    prod_acc #(.PW(8), .AW(9), .LEN(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .in_vld_i(vld[1]), .in_prod_i(prod[1]),
        .in_rdy_o(rdy[1]), .out_vld_o(ovld[1]), .out_rdy_i(ordy[1]), .out_sum_o(sum1),
        .out_ovf_o(oovf[1])
    );
    prod_acc #(.PW(8), .AW(16), .LEN(1)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[2]), .in_vld_i(vld[2]), .in_prod_i(prod[2]),
        .in_rdy_o(rdy[2]), .out_vld_o(ovld[2]), .out_rdy_i(ordy[2]), .out_sum_o(sum2),
        .out_ovf_o(oovf[2])
    );

    function automatic logic [15:0] osum(int d);
        if (d == 0) return sum0;
        if (d == 1) return {7'd0, sum1};
        return sum2;
    endfunction

    function automatic int aw_of(int d);
        return (d == 1) ? 9 : 16;
    endfunction

    function automatic int len_of(int d);
        return (d == 2) ? 1 : 4;
    endfunction

    // Reference model: frame phase, product count and the exact running total of the frame.
    int     m_phase [3];  // 0 no frame, 1 collecting, 2 result pending
    int     m_cnt   [3];
    longint m_total [3];
    longint m_sum   [3];
    logic   m_ovf   [3];

    function automatic longint fold(longint t, int aw);
        longint mask = (64'd1 << aw) - 1;
`ifdef PROD_ACC_SAT_EN
        return (t > mask) ? mask : t;
`else
        return t & mask;
`endif
    endfunction

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_phase[d] = 0; m_cnt[d] = 0; m_total[d] = 0; m_sum[d] = 0; m_ovf[d] = 1'b0;
            end else if (m_phase[d] == 2) begin
                if (ordy[d]) begin
                    m_phase[d] = 0; m_cnt[d] = 0; m_total[d] = 0;
                end
            end else if (clr[d]) begin
                m_phase[d] = 0; m_cnt[d] = 0; m_total[d] = 0;
            end else if (vld[d]) begin
                m_total[d] += longint'(prod[d]);
                m_cnt[d]++;
                if (m_cnt[d] == len_of(d)) begin
                    m_phase[d] = 2;
                    m_sum[d]   = fold(m_total[d], aw_of(d));
                    m_ovf[d]   = (m_total[d] >= (64'd1 << aw_of(d)));
                end else begin
                    m_phase[d] = 1;
                end
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("model_vld%0d", d), 32'(ovld[d]), 32'(m_phase[d] == 2));
            chk($sformatf("model_rdy%0d", d), 32'(rdy[d]), 32'(rst_n && m_phase[d] != 2));
            chk($sformatf("model_sum%0d", d), 32'(osum(d)), 32'(m_sum[d]));
            chk($sformatf("model_ovf%0d", d), 32'(oovf[d]), 32'(m_ovf[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_cmp();
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            clr[d] = 1'b0; vld[d] = 1'b0; prod[d] = 8'h00; ordy[d] = 1'b1;
        end
    endtask

    typedef struct {
        int          d;
        logic        rst, clr, vld;
        logic [7:0]  prod;
        logic        ordy;
        logic        evld, erdy;
        logic [15:0] esum;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int d, logic r, logic c, logic v, logic [7:0] p, logic o,
                                logic ev, logic er, logic [15:0] es, logic eo);
        vec_t t;
        t.d = d; t.rst = r; t.clr = c; t.vld = v; t.prod = p; t.ordy = o;
        t.evld = ev; t.erdy = er; t.esum = es; t.eovf = eo;
        tbl.push_back(t);
    endfunction

    initial begin
        logic [15:0] big_sum;
`ifdef PROD_ACC_SAT_EN
        big_sum = 16'h01FF;
`else
        big_sum = 16'h0184;
`endif
        for (int d = 0; d < 3; d++) begin
            m_phase[d] = 0; m_cnt[d] = 0; m_total[d] = 0; m_sum[d] = 0; m_ovf[d] = 1'b0;
        end

        // d rst clr vld prod ordy | vld rdy sum ovf
        add(0, 0, 0, 0, 8'h00, 1, 0, 0, 16'h0000, 0);  // reset
        add(0, 1, 0, 0, 8'h00, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h10, 1, 0, 1, 16'h0000, 0);  // normal frame
        add(0, 1, 0, 1, 8'h20, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h30, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h40, 1, 1, 0, 16'h00A0, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0, 1, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h10, 0, 0, 1, 16'h00A0, 0);  // backpressure
        add(0, 1, 0, 1, 8'h20, 0, 0, 1, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h30, 0, 0, 1, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h40, 0, 1, 0, 16'h00A0, 0);
        add(0, 1, 0, 0, 8'h00, 0, 1, 0, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h77, 0, 1, 0, 16'h00A0, 0);  // vld while not ready: ignored
        add(0, 1, 0, 0, 8'h00, 0, 1, 0, 16'h00A0, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0, 1, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h05, 1, 0, 1, 16'h00A0, 0);  // abort
        add(0, 1, 0, 1, 8'h07, 1, 0, 1, 16'h00A0, 0);
        add(0, 1, 1, 1, 8'h09, 1, 0, 1, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h01, 1, 0, 1, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h02, 1, 0, 1, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h03, 1, 0, 1, 16'h00A0, 0);
        add(0, 1, 0, 1, 8'h04, 1, 1, 0, 16'h000A, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0, 1, 16'h000A, 0);
        add(0, 1, 0, 1, 8'h01, 1, 0, 1, 16'h000A, 0);  // reset mid-frame
        add(0, 1, 0, 1, 8'h01, 1, 0, 1, 16'h000A, 0);
        add(0, 0, 0, 1, 8'h05, 1, 0, 0, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h01, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h01, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h01, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h01, 0, 1, 0, 16'h0004, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 0);  // reset with result pending
        add(0, 1, 0, 1, 8'h03, 1, 0, 1, 16'h0000, 0);  // gaps
        add(0, 1, 0, 0, 8'hFF, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 0, 8'hFF, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h04, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h05, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0, 1, 16'h0000, 0);
        add(0, 1, 0, 1, 8'h06, 1, 1, 0, 16'h0012, 0);
        add(0, 1, 0, 0, 8'h00, 1, 0, 1, 16'h0012, 0);
        add(2, 1, 0, 1, 8'hFF, 0, 1, 0, 16'h00FF, 0);  // LEN=1
        add(2, 1, 0, 0, 8'h00, 1, 0, 1, 16'h00FF, 0);
        add(1, 1, 0, 1, 8'hE1, 1, 0, 1, 16'h0000, 0);  // AW=9 overflow
        add(1, 1, 0, 1, 8'hE1, 1, 0, 1, 16'h0000, 0);
        add(1, 1, 0, 1, 8'hE1, 1, 0, 1, 16'h0000, 0);
        add(1, 1, 0, 1, 8'hE1, 1, 1, 0, big_sum, 1);
        add(1, 1, 0, 0, 8'h00, 1, 0, 1, big_sum, 1);
        add(1, 1, 0, 1, 8'h01, 1, 0, 1, big_sum, 1);
        add(1, 1, 0, 1, 8'h01, 1, 0, 1, big_sum, 1);
        add(1, 1, 0, 1, 8'h01, 1, 0, 1, big_sum, 1);
        add(1, 1, 0, 1, 8'h01, 1, 1, 0, 16'h0004, 0);
        add(1, 1, 0, 0, 8'h00, 1, 0, 1, 16'h0004, 0);

        idle_all();
        rst_n = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            int d;
            d = tbl[i].d;
            idle_all();
            rst_n   = tbl[i].rst;
            clr[d]  = tbl[i].clr;
            vld[d]  = tbl[i].vld;
            prod[d] = tbl[i].prod;
            ordy[d] = tbl[i].ordy;
            tick();
            chk($sformatf("row%0d_vld", i), 32'(ovld[d]), 32'(tbl[i].evld));
            chk($sformatf("row%0d_rdy", i), 32'(rdy[d]), 32'(tbl[i].erdy));
            chk($sformatf("row%0d_sum", i), 32'(osum(d)), 32'(tbl[i].esum));
            chk($sformatf("row%0d_ovf", i), 32'(oovf[d]), 32'(tbl[i].eovf));
        end

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int d = 0; d < 3; d++) begin
                clr[d]  = ($urandom_range(0, 15) == 0);
                vld[d]  = ($urandom_range(0, 3) != 0);
                prod[d] = 8'($urandom);
                if (d == 1 && $urandom_range(0, 1) == 1) prod[d] = prod[d] | 8'hC0;
                ordy[d] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
